fifo_ram_ctrl: RTL and testbench



---
 rtl/fifo_ctrl_pkg.sv | 32 +++
 rtl/fifo_rd_valid_pipe.sv | 31 +++
 rtl/fifo_ram_ctrl.sv | 157 +++++++++++++++
 tb/tb_fifo_ram_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared constants, types and elaboration helpers for the
// FIFO RAM controller (fifo_ram_ctrl) and its read-valid pipeline.
package fifo_ctrl_pkg;

    // Legal range of the RAM read latency (non-pipelined / pipelined macro).
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Accepted-operation combination for one clock, encoded as {write, read}.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    // The word count needs one more bit than the pointers so that a full
    // FIFO (2**addr_w words) is distinguishable from an empty one.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Thresholds must be ordered and must not exceed the FIFO depth.
    function automatic bit thresh_ok(input int addr_w, input int afull_th, input int aempty_th);
        return (aempty_th < afull_th) && (afull_th <= (1 << addr_w));
    endfunction

    function automatic bit rd_lat_ok(input int rd_latency);
        return (rd_latency >= RD_LAT_MIN) && (rd_latency <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/fifo_rd_valid_pipe.sv
// fifo_rd_valid_pipe: LAT-deep shift register that turns the RAM read enable
// into a data-valid strobe aligned with the RAM read latency. An asynchronous
// reset flushes any strobes still in flight.
module fifo_rd_valid_pipe
    import fifo_ctrl_pkg::*;
#(
    parameter int LAT = RD_LAT_MAX
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic REN,
    output logic DVLD
);

    logic [LAT-1:0] sr_q;

    // Shift the accepted-read strobe one stage per clock.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= REN;
            for (int i = 1; i < LAT; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign DVLD = sr_q[LAT-1];

endmodule

// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: single-clock FIFO controller for an external dual-port RAM.
// Owns the write/read pointers and word count, drives the RAM address and
// enable strobes, and produces registered FULL/EMPTY/threshold/error flags
// plus a read-data-valid strobe.
// Optional feature macro: FIFO_CTRL_THRESH_EN -- when defined, AFULL/AEMPTY
// are registered compares against AFULL_TH/AEMPTY_TH; otherwise they mirror
// FULL/EMPTY.
module fifo_ram_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int RD_LATENCY = 2,
    parameter int AFULL_TH   = 120,
    parameter int AEMPTY_TH  = 8
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              WE,
    input  logic              RE,
    output logic [ADDR_W-1:0] RAM_WADDR,
    output logic              RAM_WEN,
    output logic [ADDR_W-1:0] RAM_RADDR,
    output logic              RAM_REN,
    output logic              DVLD,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic [ADDR_W:0]   WRCNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int CW = cnt_width(ADDR_W);
    localparam logic [CW-1:0]     DEPTH_C = CW'(2 ** ADDR_W);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // Reject illegal configurations at elaboration time.
    if (!rd_lat_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("fifo_ram_ctrl: RD_LATENCY must be 1 or 2");
    end
    if (!thresh_ok(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
        $error("fifo_ram_ctrl: need AEMPTY_TH < AFULL_TH <= 2**ADDR_W");
    end

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_acc, rd_acc;
    fifo_op_e          op;

    // Acceptance uses only the registered flags, so the count can never
    // exceed the depth or drop below zero.
    assign wr_acc = WE & ~full_q;
    assign rd_acc = RE & ~empty_q;
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    // Next pointers, next count and next flags from the accepted operations.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        case (op)
            OP_WR: begin
                wptr_d  = wptr_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end
            OP_RD: begin
                rptr_d  = rptr_q + PTR_ONE;
                count_d = count_q - CNT_ONE;
            end
            OP_WR_RD: begin
                wptr_d = wptr_q + PTR_ONE;
                rptr_d = rptr_q + PTR_ONE;
            end
            default: begin
            end
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        // A request is rejected exactly when its side is blocked by a flag.
        ovf_d   = WE & full_q;
        udf_d   = RE & empty_q;
    end

    // Pointer, count and flag registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef FIFO_CTRL_THRESH_EN
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic afull_q, aempty_q;

    // Threshold flags registered from the next count, aligned with FULL/EMPTY.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (count_d >= AFULL_C);
            aempty_q <= (count_d <= AEMPTY_C);
        end
    end

    assign AFULL  = afull_q;
    assign AEMPTY = aempty_q;
`else
    assign AFULL  = full_q;
    assign AEMPTY = empty_q;
`endif

    fifo_rd_valid_pipe #(
        .LAT (RD_LATENCY)
    ) u_rd_valid_pipe (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .REN     (rd_acc),
        .DVLD    (DVLD)
    );

    // Enables are additionally masked by reset so the RAM sees no strobe
    // while the controller is held in reset.
    assign RAM_WEN   = wr_acc & RESET_N;
    assign RAM_REN   = rd_acc & RESET_N;
    assign RAM_WADDR = wptr_q;
    assign RAM_RADDR = rptr_q;
    assign WRCNT     = count_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb_fifo_ram_ctrl: randomized and directed checks of fifo_ram_ctrl against a
// word-count/queue level reference model. Two instances (RD_LATENCY 2 and 1)
// share the same stimulus.
module tb_fifo_ram_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 3;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;
    logic WE      = 1'b0;
    logic RE      = 1'b0;

    logic [AW-1:0] waddr2, raddr2, waddr1, raddr1;
    logic          wen2, ren2, dvld2, full2, empty2, afull2, aempty2, ovf2, udf2;
    logic          wen1, ren1, dvld1, full1, empty1, afull1, aempty1, ovf1, udf1;
    logic [AW:0]   cnt2, cnt1;

    fifo_ram_ctrl #(.ADDR_W(AW), .RD_LATENCY(2), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_dut2 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .WE(WE), .RE(RE),
        .RAM_WADDR(waddr2), .RAM_WEN(wen2), .RAM_RADDR(raddr2), .RAM_REN(ren2),
        .DVLD(dvld2), .FULL(full2), .EMPTY(empty2), .AFULL(afull2), .AEMPTY(aempty2),
        .WRCNT(cnt2), .OVERFLOW(ovf2), .UNDERFLOW(udf2)
    );

    fifo_ram_ctrl #(.ADDR_W(AW), .RD_LATENCY(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_dut1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .WE(WE), .RE(RE),
        .RAM_WADDR(waddr1), .RAM_WEN(wen1), .RAM_RADDR(raddr1), .RAM_REN(ren1),
        .DVLD(dvld1), .FULL(full1), .EMPTY(empty1), .AFULL(afull1), .AEMPTY(aempty1),
        .WRCNT(cnt1), .OVERFLOW(ovf1), .UNDERFLOW(udf1)
    );

    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    // Reference model: number of stored words, totals of accepted writes and
    // reads (pointers are these totals modulo depth), last-cycle rejections,
    // and the set of clock cycles in which a read was accepted.
    int m_cnt = 0;
    int m_wr  = 0;
    int m_rd  = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;
    int cyc   = 0;
    bit rd_at[int];
    bit e_wen, e_ren, o_wen, o_ren;

    function automatic bit exp_afull();
`ifdef FIFO_CTRL_THRESH_EN
        return m_cnt >= AF;
`else
        return m_cnt == DEPTH;
`endif
    endfunction

    function automatic bit exp_aempty();
`ifdef FIFO_CTRL_THRESH_EN
        return m_cnt <= AE;
`else
        return m_cnt == 0;
`endif
    endfunction

    function automatic bit exp_dvld(input int lat);
        return rd_at.exists(cyc - lat) != 0;
    endfunction

    // One clock of stimulus; called at posedge+1, returns at posedge+1.
    task automatic drive(input bit we, input bit re);
        bit wa, ra;
        WE = we;
        RE = re;
        wa = we && (m_cnt < DEPTH);
        ra = re && (m_cnt > 0);
        e_wen = wa;
        e_ren = ra;
        #1;
        o_wen = wen2;
        o_ren = ren2;
        @(posedge CLOCK);
        if (ra) rd_at[cyc] = 1'b1;
        cyc++;
        m_cnt = m_cnt + int'(wa) - int'(ra);
        if (wa) m_wr++;
        if (ra) m_rd++;
        m_ovf = we && !wa;
        m_udf = re && !ra;
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        m_cnt = 0;
        m_wr  = 0;
        m_rd  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        rd_at.delete();
        #1;
    endtask

    task automatic test_reset();
        WE = 1'b1;
        RE = 1'b1;
        do_reset();
        #22;
        total++; if (cnt2 !== 5'd0) begin bad++; $display("FAIL reset_wrcnt got=%0d want=0", cnt2); end
        total++; if (empty2 !== 1'b1 || full2 !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%b%b want=10", empty2, full2); end
        total++; if (afull2 !== 1'b0 || aempty2 !== 1'b1) begin bad++; $display("FAIL reset_thresh got=%b%b want=01", afull2, aempty2); end
        total++; if (waddr2 !== 4'd0 || raddr2 !== 4'd0) begin bad++; $display("FAIL reset_ptrs got=%0d/%0d want=0/0", waddr2, raddr2); end
        total++; if (wen2 !== 1'b0 || ren2 !== 1'b0) begin bad++; $display("FAIL reset_enables got=%b%b want=00", wen2, ren2); end
        total++; if (dvld2 !== 1'b0 || dvld1 !== 1'b0 || ovf2 !== 1'b0 || udf2 !== 1'b0) begin
            bad++; $display("FAIL reset_pulses got=%b%b%b%b want=0000", dvld2, dvld1, ovf2, udf2);
        end
        WE = 1'b0;
        RE = 1'b0;
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;
        total++; if (cnt2 !== 5'd0 || empty2 !== 1'b1) begin bad++; $display("FAIL reset_release got=%0d/%b want=0/1", cnt2, empty2); end
        $display("reset: done");
    endtask

    task automatic test_fill();
        logic [AW:0]   exp_c;
        logic [AW-1:0] exp_a;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b0);
            exp_c = i[AW:0];
            exp_a = i[AW-1:0];
            total++; if (cnt2 !== exp_c) begin bad++; $display("FAIL fill_wrcnt i=%0d got=%0d want=%0d", i, cnt2, exp_c); end
            total++; if (full2 !== (i == DEPTH)) begin bad++; $display("FAIL fill_full i=%0d got=%b want=%b", i, full2, i == DEPTH); end
            total++; if (waddr2 !== exp_a) begin bad++; $display("FAIL fill_waddr i=%0d got=%0d want=%0d", i, waddr2, exp_a); end
            total++; if (afull2 !== exp_afull()) begin bad++; $display("FAIL fill_afull i=%0d got=%b want=%b", i, afull2, exp_afull()); end
            total++; if (aempty2 !== exp_aempty()) begin bad++; $display("FAIL fill_aempty i=%0d got=%b want=%b", i, aempty2, exp_aempty()); end
            $display("fill: write %0d wrcnt=%0d full=%b afull=%b aempty=%b", i, cnt2, full2, afull2, aempty2);
        end
        drive(1'b1, 1'b0);
        total++; if (ovf2 !== 1'b1 || cnt2 !== 5'd16 || waddr2 !== 4'd0) begin
            bad++; $display("FAIL fill_overflow got=%b/%0d/%0d want=1/16/0", ovf2, cnt2, waddr2);
        end
        drive(1'b0, 1'b0);
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL fill_ovf_pulse got=%b want=0", ovf2); end
        $display("fill: rejected write overflow seen");
    endtask

    task automatic test_full_both();
        drive(1'b1, 1'b1);
        total++; if (o_wen !== 1'b0 || o_ren !== 1'b1) begin bad++; $display("FAIL full_both_en got=%b%b want=01", o_wen, o_ren); end
        total++; if (ovf2 !== 1'b1 || udf2 !== 1'b0) begin bad++; $display("FAIL full_both_ovf got=%b%b want=10", ovf2, udf2); end
        total++; if (cnt2 !== 5'd15 || full2 !== 1'b0) begin bad++; $display("FAIL full_both_cnt got=%0d/%b want=15/0", cnt2, full2); end
        total++; if (raddr2 !== 4'd1) begin bad++; $display("FAIL full_both_raddr got=%0d want=1", raddr2); end
        drive(1'b0, 1'b0);
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL full_both_pulse got=%b want=0", ovf2); end
        $display("full_both: wrcnt=%0d raddr=%0d", cnt2, raddr2);
    endtask

    task automatic test_read_burst();
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            drive(1'b0, t < 5);
            total++; if (dvld2 !== (t >= 1 && t <= 5)) begin bad++; $display("FAIL burst_dvld_lat2 t=%0d got=%b want=%b", t, dvld2, (t >= 1 && t <= 5)); end
            total++; if (dvld1 !== (t <= 4)) begin bad++; $display("FAIL burst_dvld_lat1 t=%0d got=%b want=%b", t, dvld1, (t <= 4)); end
            $display("burst: t=%0d re=%b dvld_lat2=%b dvld_lat1=%b", t, t < 5, dvld2, dvld1);
        end
        total++; if (cnt2 !== 5'd10) begin bad++; $display("FAIL burst_wrcnt got=%0d want=10", cnt2); end
    endtask

    task automatic test_empty_both();
        for (int k = 0; k < 40 && m_cnt > 0; k++) drive(1'b0, 1'b1);
        total++; if (empty2 !== 1'b1 || cnt2 !== 5'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d want=1/0", empty2, cnt2); end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        total++; if (o_wen !== 1'b1 || o_ren !== 1'b0) begin bad++; $display("FAIL empty_both_en got=%b%b want=10", o_wen, o_ren); end
        total++; if (udf2 !== 1'b1 || ovf2 !== 1'b0) begin bad++; $display("FAIL empty_both_udf got=%b%b want=10", udf2, ovf2); end
        total++; if (cnt2 !== 5'd1 || empty2 !== 1'b0) begin bad++; $display("FAIL empty_both_cnt got=%0d/%b want=1/0", cnt2, empty2); end
        total++; if (dvld2 !== 1'b0 || dvld1 !== 1'b0) begin bad++; $display("FAIL empty_both_dvld got=%b%b want=00", dvld2, dvld1); end
        drive(1'b0, 1'b0);
        total++; if (dvld2 !== 1'b0 || udf2 !== 1'b0) begin bad++; $display("FAIL empty_both_after got=%b%b want=00", dvld2, udf2); end
        $display("empty_both: wrcnt=%0d underflow pulse seen", cnt2);
    endtask

    task automatic test_random();
        logic [27:0] obs_v, exp_v;
        int pw, pr;
        for (int ph = 0; ph < 3; ph++) begin
            case (ph)
                0: begin pw = 75; pr = 25; end
                1: begin pw = 25; pr = 75; end
                default: begin pw = 55; pr = 50; end
            endcase
            for (int n = 0; n < 150; n++) begin
                drive($urandom_range(99) < pw, $urandom_range(99) < pr);
                obs_v = {cnt2, full2, empty2, afull2, aempty2, waddr2, raddr2,
                         ovf2, udf2, dvld2, dvld1, cnt1, o_wen, o_ren};
                exp_v = {m_cnt[AW:0], m_cnt == DEPTH, m_cnt == 0, exp_afull(), exp_aempty(),
                         m_wr[AW-1:0], m_rd[AW-1:0], m_ovf, m_udf, exp_dvld(2), exp_dvld(1),
                         m_cnt[AW:0], e_wen, e_ren};
                total++;
                if (obs_v !== exp_v) begin
                    bad++;
                    $display("FAIL random ph=%0d n=%0d got=%07h want=%07h", ph, n, obs_v, exp_v);
                end
                $display("random: ph=%0d n=%0d we=%b re=%b wrcnt=%0d dvld=%b", ph, n, WE, RE, cnt2, dvld2);
            end
        end
    endtask

    task automatic test_reset_midburst();
        for (int k = 0; k < 40 && m_cnt < 4; k++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        total++; if (dvld2 !== 1'b1 || dvld1 !== 1'b1) begin bad++; $display("FAIL midrst_pre_dvld got=%b%b want=11", dvld2, dvld1); end
        #1;
        do_reset();
        total++; if (dvld2 !== 1'b0 || dvld1 !== 1'b0) begin bad++; $display("FAIL midrst_dvld got=%b%b want=00", dvld2, dvld1); end
        total++; if (empty2 !== 1'b1 || cnt2 !== 5'd0) begin bad++; $display("FAIL midrst_state got=%b/%0d want=1/0", empty2, cnt2); end
        total++; if (ren2 !== 1'b0 || raddr2 !== 4'd0 || waddr2 !== 4'd0) begin
            bad++; $display("FAIL midrst_ptrs got=%b/%0d/%0d want=0/0/0", ren2, raddr2, waddr2);
        end
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        RE = 1'b0;
        @(posedge CLOCK);
        #1;
        total++; if (waddr2 !== 4'd0) begin bad++; $display("FAIL midrst_waddr got=%0d want=0", waddr2); end
        drive(1'b1, 1'b0);
        total++; if (o_wen !== 1'b1 || cnt2 !== 5'd1 || waddr2 !== 4'd1) begin
            bad++; $display("FAIL midrst_write got=%b/%0d/%0d want=1/1/1", o_wen, cnt2, waddr2);
        end
        total++; if (dvld2 !== 1'b0) begin bad++; $display("FAIL midrst_nodvld got=%b want=0", dvld2); end
        $display("reset_midburst: first write after release wrcnt=%0d waddr=%0d", cnt2, waddr2);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_both();
        test_read_burst();
        test_empty_both();
        test_random();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
